systolic_sched: RTL and testbench
=================================

// Module: systolic_sched
// PURPOSE
//  Sequencer for the 8x8 PE systolic array. On start it fetches K operand beats from the
//  A/B operand buffers and skews them so that row i and column j lag lane 0 by i and j cycles.
//  It drives the enable/commit-marker handshake, waits for all 64 PEs to report ready,
//  and then pulses the writeback enable. It sits between the tile dispatcher and the array.
// PARAMETERS
//  DIM       8    array rows = array cols; fixed to 8 by the array
//  KW        10   width of the reduction-length field (K max = 2**KW-1)
//  DRAIN_MAX 64   maximum number of DRAIN cycles allowed before err is flagged
// PORTS
//  clk          in   1          clock
//  rst          in   1          asynchronous reset, active-high
//  start        in   1          launch pulse; sampled only in IDLE
//  abort        in   1          synchronous abort; returns the block to IDLE
//  k_len        in   KW         reduction length K, sampled with start
//  mixed_in     in   1          precision mode, latched with start
//  addr_in      in   addrgen_t  writeback address mode, latched with start
//  op_rd_en     out  1          operand buffer read strobe
//  op_rd_k      out  KW         beat index k read this cycle
//  op_a         in   DIM*32     A column k (row i in lane i); valid 1 cycle after op_rd_en
//  op_b         in   DIM*32     B row k (col j in lane j); valid 1 cycle after op_rd_en
//  enleft       out  DIM        row-i valid into column 0
//  enup         out  DIM        col-j valid into row 0
//  cmleft       out  DIM        row-i last-beat marker
//  cmup         out  DIM        col-j last-beat marker
//  aleft        out  DIM*32     row operands
//  bup          out  DIM*32     column operands
//  mixed        out  1          latched mixed_in
//  addr_type    out  addrgen_t  latched addr_in
//  wben         out  1          one-cycle writeback enable
//  out_ready    in   DIM*DIM    per-PE result-ready flags
//  busy         out  1          high whenever the state is not IDLE
//  done         out  1          one-cycle pulse at the end of a tile
//  err          out  1          sticky drain-timeout flag; cleared by the next start
// BEHAVIOUR
//  Reset: every output is 0; all skew lines are cleared; state is IDLE; latched mode is 0.
//  FSM: IDLE -> FETCH -> FEED -> DRAIN -> WB -> IDLE.
//   IDLE:  on start with k_len != 0, latch K, mixed and addr; clear err; go to FETCH.
//          On start with k_len == 0, pulse done the next cycle; no enables, no wben.
//          start while busy is ignored.
//   FETCH: op_rd_en = 1 for K consecutive cycles with op_rd_k = 0..K-1, then go to FEED.
//   FEED:  wait until the last beat exits the deepest skew stage (DIM-1 extra cycles),
//          then go to DRAIN.
//   DRAIN: when &out_ready, go to WB. If DRAIN_MAX cycles elapse first, set err and go to WB.
//   WB:    wben = 1 for one cycle; done = 1 in the same cycle; next state is IDLE.
//  Lane-0 beat: valid the cycle after op_rd_en; lane-0 en = 1; cm = 1 only for k = K-1.
//  Skew: row i and col j outputs (en, cm, data) equal the lane-0 stream delayed by i/j cycles.
//   Lane 0 has no added delay. Lanes use registered delay lines, one per lane.
//  Timing with start at cycle 0:
//   - beat k reaches lane i at cycle k+2+i
//   - last enleft[7] is at cycle K+8
//   - earliest wben is the cycle after &out_ready is observed in DRAIN
//  Data outputs hold 0 whenever the corresponding en is 0; no stale operands leak out.
//  abort: next cycle, state is IDLE, all enables/markers/skew lines are cleared, op_rd_en = 0.
//   No wben and no done are produced. abort has priority over every other transition.
//  Async rst mid-tile: immediate return to the reset values; the array is expected to be reset too.
// STRUCTURE
//  para_pkg (params): add sched_state_t enum {IDLE,FETCH,FEED,DRAIN,WB}, ARR_DIM = 8.
//   Reuse the existing addrgen_t.
//  Sub-module skew_line #(DEPTH, W): a DEPTH-stage {en,cm,data} shift register with sync clear.
//   Instantiate 2*DIM of them, DEPTH = lane index; DEPTH = 0 is a passthrough.
//  Top level holds the FSM, the beat counter (KW bits) and the drain counter.
// TESTING
//  K=4, op_a lane i = 0x100+k, all out_ready = 1 in DRAIN:
//   -> enleft[3] high at cycles 5..8; cmleft[3] only at cycle 8; one wben; one done.
//  K=1: cm is coincident with the only en on every lane; enleft[7] at cycle 9; wben follows.
//  k_len=0 start: done at cycle 1; no op_rd_en/en/wben ever; busy stays 0.
//  out_ready withheld 10 DRAIN cycles, then set:
//   -> wben exactly 1 cycle after all 64 are seen high; err = 0.
//  out_ready never set: err = 1 after DRAIN_MAX cycles; wben and done still pulse once;
//   a later start clears err.
//  abort at cycle 4 of K=8: all en/cm are 0 from cycle 5; no wben/done; a new start then
//   runs cleanly. Also repeat with rst asserted mid-FEED.

Source files
------------

// File: rtl/systolic_sched_pkg.sv
// systolic_sched_pkg: shared sizes, address-mode and sequencer-state types
package systolic_sched_pkg;
  localparam int ARR_DIM   = 8;
  localparam int KW        = 10;
  localparam int DRAIN_MAX = 64;
  typedef enum logic [1:0] {ADDR_ROW, ADDR_COL, ADDR_TILE, ADDR_DIAG} addrgen_t;
  typedef enum logic [2:0] {IDLE, FETCH, FEED, DRAIN, WB} sched_state_t;
endpackage

// File: rtl/systolic_sched_if.sv
// systolic_sched_if: dispatcher, operand-buffer and array signals of the sequencer
interface systolic_sched_if;
  import systolic_sched_pkg::*;
  logic                       start;
  logic                       abort;
  logic [KW-1:0]              k_len;
  logic                       mixed_in;
  addrgen_t                   addr_in;
  logic                       op_rd_en;
  logic [KW-1:0]              op_rd_k;
  logic [ARR_DIM*32-1:0]      op_a;
  logic [ARR_DIM*32-1:0]      op_b;
  logic [ARR_DIM-1:0]         enleft;
  logic [ARR_DIM-1:0]         enup;
  logic [ARR_DIM-1:0]         cmleft;
  logic [ARR_DIM-1:0]         cmup;
  logic [ARR_DIM*32-1:0]      aleft;
  logic [ARR_DIM*32-1:0]      bup;
  logic                       mixed;
  addrgen_t                   addr_type;
  logic                       wben;
  logic [ARR_DIM*ARR_DIM-1:0] out_ready;
  logic                       busy;
  logic                       done;
  logic                       err;
  modport master (
    output start, abort, k_len, mixed_in, addr_in, op_a, op_b, out_ready,
    input  op_rd_en, op_rd_k, enleft, enup, cmleft, cmup, aleft, bup,
           mixed, addr_type, wben, busy, done, err
  );
  modport slave (
    input  start, abort, k_len, mixed_in, addr_in, op_a, op_b, out_ready,
    output op_rd_en, op_rd_k, enleft, enup, cmleft, cmup, aleft, bup,
           mixed, addr_type, wben, busy, done, err
  );
endinterface

// File: rtl/systolic_sched_skew_line.sv
// skew_line: DEPTH-stage {en,cm,data} delay line with sync clear; DEPTH 0 is a wire
module skew_line #(
  parameter int DEPTH = 0,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         cm,
  input  logic [W-1:0] data,
  output logic         dly_en,
  output logic         dly_cm,
  output logic [W-1:0] dly_data
);
  if (DEPTH == 0) begin : g_pass
    logic unused;
    assign unused = clk ^ rst ^ clr;
    assign {dly_en, dly_cm, dly_data} = {en, cm, data};
  end else begin : g_sr
    logic [DEPTH-1:0][W+1:0] sr;
    // shift one stage per cycle; clr flushes every stage at once
    always_ff @(posedge clk or posedge rst)
      if (rst) sr <= '0;
      else if (clr) sr <= '0;
      else begin
        sr[0] <= {en, cm, data};
        for (int s = 1; s < DEPTH; s++) sr[s] <= sr[s-1];
      end
    assign {dly_en, dly_cm, dly_data} = sr[DEPTH-1];
  end
endmodule

// File: rtl/systolic_sched.sv
// systolic_sched: fetches K operand beats, skews them into the 8x8 array, drains and writes back
module systolic_sched
  import systolic_sched_pkg::*;
(
  input logic             clk,
  input logic             rst,
  systolic_sched_if.slave bus
);
  localparam int CW = $clog2(DRAIN_MAX);
  sched_state_t  state;
  logic [KW-1:0] k_reg;
  logic [CW-1:0] cnt;
  logic          beat;
  logic          beat_cm;
  logic          last;
  logic          all_ready;
  assign last      = bus.op_rd_k == k_reg - KW'(1);
  assign all_ready = &bus.out_ready;
  assign bus.busy  = state != IDLE;
  // tile sequencer; abort wins over every transition and suppresses wben/done
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      k_reg         <= '0;
      cnt           <= '0;
      bus.op_rd_en  <= 1'b0;
      bus.op_rd_k   <= '0;
      bus.mixed     <= 1'b0;
      bus.addr_type <= ADDR_ROW;
      bus.wben      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else if (bus.abort) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.op_rd_en <= 1'b0;
      bus.wben     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.wben <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bus.err  <= 1'b0;
          bus.done <= bus.k_len == '0;
          if (bus.k_len != '0) begin
            state         <= FETCH;
            k_reg         <= bus.k_len;
            bus.mixed     <= bus.mixed_in;
            bus.addr_type <= bus.addr_in;
            bus.op_rd_en  <= 1'b1;
            bus.op_rd_k   <= '0;
          end
        end
        FETCH: if (last) begin
          bus.op_rd_en <= 1'b0;
          state        <= FEED;
          cnt          <= '0;
        end else bus.op_rd_k <= bus.op_rd_k + KW'(1);
        FEED: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ARR_DIM - 1)) begin
            cnt   <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          cnt <= cnt + CW'(1);
          if (all_ready || cnt == CW'(DRAIN_MAX - 1)) begin
            state    <= WB;
            bus.wben <= 1'b1;
            bus.done <= 1'b1;
            bus.err  <= !all_ready;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  // lane-0 beat is valid the cycle after its read strobe, when the buffer data arrives
  always_ff @(posedge clk or posedge rst)
    if (rst) {beat, beat_cm} <= 2'b00;
    else {beat, beat_cm} <= bus.abort ? 2'b00 : {bus.op_rd_en, bus.op_rd_en & last};
  for (genvar i = 0; i < ARR_DIM; i++) begin : g_lane
    skew_line #(.DEPTH(i), .W(32)) u_row (
      .clk(clk), .rst(rst), .clr(bus.abort), .en(beat), .cm(beat_cm),
      .data(beat ? bus.op_a[i*32 +: 32] : 32'h0),
      .dly_en(bus.enleft[i]), .dly_cm(bus.cmleft[i]), .dly_data(bus.aleft[i*32 +: 32])
    );
    skew_line #(.DEPTH(i), .W(32)) u_col (
      .clk(clk), .rst(rst), .clr(bus.abort), .en(beat), .cm(beat_cm),
      .data(beat ? bus.op_b[i*32 +: 32] : 32'h0),
      .dly_en(bus.enup[i]), .dly_cm(bus.cmup[i]), .dly_data(bus.bup[i*32 +: 32])
    );
  end
endmodule

// File: tb/tb_systolic_sched.sv
// tb_systolic_sched: scoreboard bench for the systolic sequencer
module tb_systolic_sched;
  import systolic_sched_pkg::*;
  typedef struct {logic [31:0] d; logic cm; int t;} exp_t;
  logic clk = 1'b0;
  logic rst;
  int tests = 0, fails = 0, cyc = 0, t0 = 0, rel = 0, kk = 0, next_k = 0;
  int nrd, nwb, ndone, nen, nbusy, wb_at, done_at, first3, last3, last7;
  exp_t q[2][ARR_DIM][$];
  systolic_sched_if bus();
  systolic_sched dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // operand buffer: one-cycle read latency, garbage when not read
  always @(posedge clk)
    for (int i = 0; i < ARR_DIM; i++) begin
      bus.op_a[i*32 +: 32] <= bus.op_rd_en ? 32'h100 + 32'(bus.op_rd_k) + 32'(i << 16) : 32'hDEAD0000 + 32'(i);
      bus.op_b[i*32 +: 32] <= bus.op_rd_en ? 32'h200 + 32'(bus.op_rd_k) + 32'(i << 16) : 32'hBEEF0000 + 32'(i);
    end

  task automatic clr_stats();
    nrd = 0; nwb = 0; ndone = 0; nen = 0; nbusy = 0; next_k = 0;
    wb_at = -1; done_at = -1; first3 = -1; last3 = -1; last7 = -1;
  endtask

  task automatic flush();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < ARR_DIM; i++) q[s][i].delete();
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rel = cyc - t0;
    for (int i = 0; i < ARR_DIM; i++)
      for (int s = 0; s < 2; s++) begin
        logic e, c;
        logic [31:0] d;
        exp_t x;
        e = s != 0 ? bus.enup[i] : bus.enleft[i];
        c = s != 0 ? bus.cmup[i] : bus.cmleft[i];
        d = s != 0 ? bus.bup[i*32 +: 32] : bus.aleft[i*32 +: 32];
        while (q[s][i].size() > 0 && q[s][i][0].t < cyc) begin
          tests++; fails++;
          $display("FAIL lane_missing s%0d lane%0d: no beat at cycle %0d, want data %0h", s, i, q[s][i][0].t - t0, q[s][i][0].d);
          void'(q[s][i].pop_front());
        end
        tests++;
        if (e) begin
          if (q[s][i].size() == 0) begin
            fails++;
            $display("FAIL lane_unexpected s%0d lane%0d rel %0d: got en=1 data %0h, want en=0", s, i, rel, d);
          end else begin
            x = q[s][i].pop_front();
            if (d !== x.d || c !== x.cm || cyc !== x.t) begin
              fails++;
              $display("FAIL lane_beat s%0d lane%0d: got d=%0h cm=%0b rel=%0d want d=%0h cm=%0b rel=%0d", s, i, d, c, rel, x.d, x.cm, x.t - t0);
            end
          end
        end else if (c !== 1'b0 || d !== 32'h0) begin
          fails++;
          $display("FAIL lane_leak s%0d lane%0d rel %0d: got cm=%0b d=%0h want 0", s, i, rel, c, d);
        end
      end
    if (bus.enleft[3]) begin
      if (first3 < 0) first3 = rel;
      last3 = rel;
    end
    if (bus.enleft[7]) last7 = rel;
    if (|{bus.enleft, bus.enup}) nen++;
    if (bus.busy) nbusy++;
    if (bus.wben) begin nwb++; wb_at = rel; end
    if (bus.done) begin ndone++; done_at = rel; end
    if (bus.op_rd_en) begin
      tests++;
      if (bus.op_rd_k !== KW'(next_k) || rel != 1 + next_k) begin
        fails++;
        $display("FAIL rd_seq: got k=%0d at rel %0d want k=%0d at rel %0d", bus.op_rd_k, rel, next_k, 1 + next_k);
      end
      for (int i = 0; i < ARR_DIM; i++)
        for (int s = 0; s < 2; s++) begin
          exp_t x;
          x.d  = (s != 0 ? 32'h200 : 32'h100) + 32'(next_k) + 32'(i << 16);
          x.cm = next_k == kk - 1;
          x.t  = cyc + 1 + i;
          q[s][i].push_back(x);
        end
      next_k++;
      nrd++;
    end
  endtask

  task automatic launch(input int k, input logic mx, input addrgen_t ad);
    clr_stats();
    kk = k;
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    bus.mixed_in = mx;
    bus.addr_in = ad;
    t0 = cyc;
    rel = 0;
  endtask

  task automatic run_tile(input int k, input int mode, input logic mx, input addrgen_t ad, input bit poke, input int stop_at);
    int exp_wb;
    logic [ARR_DIM*ARR_DIM-1:0] partial;
    partial = {(ARR_DIM*ARR_DIM){1'b1}} ^ ((ARR_DIM*ARR_DIM)'(1) << 37);
    launch(k, mx, ad);
    while (rel < 400 && !(ndone > 0 && !bus.busy) && rel != stop_at) begin
      bus.out_ready = mode == 0 ? '1 : mode == 1 ? (rel >= k + 19 ? '1 : '0) : partial;
      bus.start = rel == 0 || (poke && rel == 6);
      bus.k_len = (poke && rel == 6) ? KW'(2) : KW'(k);
      tick();
      if (rel == 1) begin
        tests++;
        if (bus.err !== 1'b0 || bus.mixed !== mx || bus.addr_type !== ad) begin
          fails++;
          $display("FAIL start_latch: got err=%0b mixed=%0b addr=%0d want 0 %0b %0d", bus.err, bus.mixed, bus.addr_type, mx, ad);
        end
        bus.mixed_in = ~mx;
        bus.addr_in = addrgen_t'(~ad);
      end
    end
    bus.start = 1'b0;
    if (stop_at >= 0) return;
    exp_wb = mode == 0 ? k + 10 : mode == 1 ? k + 20 : k + 73;
    tests++;
    if (rel >= 400) begin fails++; $display("FAIL tile_timeout K=%0d: got no finish by rel %0d, want done", k, rel); end
    tests++;
    if (nwb !== 1 || wb_at !== exp_wb) begin fails++; $display("FAIL wben K=%0d: got %0d pulses at rel %0d want 1 at %0d", k, nwb, wb_at, exp_wb); end
    tests++;
    if (ndone !== 1 || done_at !== exp_wb) begin fails++; $display("FAIL done K=%0d: got %0d pulses at rel %0d want 1 at %0d", k, ndone, done_at, exp_wb); end
    tests++;
    if (nrd !== k) begin fails++; $display("FAIL rd_count K=%0d: got %0d want %0d", k, nrd, k); end
    tests++;
    if (first3 !== 5 || last3 !== k + 4) begin fails++; $display("FAIL lane3_window K=%0d: got %0d..%0d want 5..%0d", k, first3, last3, k + 4); end
    tests++;
    if (last7 !== k + 8) begin fails++; $display("FAIL lane7_last K=%0d: got %0d want %0d", k, last7, k + 8); end
    tests++;
    if (bus.err !== (mode == 2)) begin fails++; $display("FAIL err K=%0d: got %0b want %0b", k, bus.err, mode == 2); end
    tests++;
    if (bus.mixed !== mx || bus.addr_type !== ad) begin fails++; $display("FAIL mode_hold: got %0b %0d want %0b %0d", bus.mixed, bus.addr_type, mx, ad); end
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < ARR_DIM; i++) begin
        tests++;
        if (q[s][i].size() != 0) begin fails++; $display("FAIL beats_left s%0d lane%0d: got %0d pending want 0", s, i, q[s][i].size()); end
      end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.k_len = '0; bus.mixed_in = 1'b0;
    bus.addr_in = ADDR_ROW; bus.out_ready = '0;
    #1;
    for (int n = 0; n < 2; n++) begin
      tests++;
      if ({bus.enleft, bus.enup, bus.cmleft, bus.cmup, bus.aleft, bus.bup, bus.op_rd_en, bus.op_rd_k,
           bus.wben, bus.done, bus.busy, bus.err, bus.mixed, bus.addr_type} !== '0) begin
        fails++;
        $display("FAIL reset_outputs: got en=%0h/%0h rd=%0b wb=%0b done=%0b busy=%0b err=%0b want all 0",
                 bus.enleft, bus.enup, bus.op_rd_en, bus.wben, bus.done, bus.busy, bus.err);
      end
      tick(); tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_len();
    launch(0, 1'b0, ADDR_ROW);
    for (int n = 0; n < 20; n++) begin
      tick();
      bus.start = 1'b0;
    end
    tests++;
    if (ndone !== 1 || done_at !== 1) begin fails++; $display("FAIL zero_done: got %0d pulses at rel %0d want 1 at 1", ndone, done_at); end
    tests++;
    if (nrd !== 0 || nen !== 0 || nwb !== 0 || nbusy !== 0) begin
      fails++;
      $display("FAIL zero_quiet: got rd=%0d en=%0d wb=%0d busy=%0d want 0 0 0 0", nrd, nen, nwb, nbusy);
    end
  endtask

  task automatic test_timeout_then_clear();
    run_tile(2, 2, 1'b0, ADDR_TILE, 1'b0, -1);
    tests++;
    if (bus.err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %0b want 1", bus.err); end
    run_tile(3, 0, 1'b1, ADDR_ROW, 1'b0, -1);
  endtask

  task automatic test_abort();
    run_tile(8, 0, 1'b1, ADDR_COL, 1'b0, 4);
    bus.abort = 1'b1;
    flush();
    nrd = 0; nen = 0; nwb = 0; ndone = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      bus.abort = 1'b0;
    end
    tests++;
    if (nen !== 0 || nrd !== 0) begin fails++; $display("FAIL abort_quiet: got en=%0d rd=%0d want 0 0", nen, nrd); end
    tests++;
    if (nwb !== 0 || ndone !== 0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_nowb: got wb=%0d done=%0d busy=%0b want 0 0 0", nwb, ndone, bus.busy);
    end
    run_tile(3, 0, 1'b0, ADDR_TILE, 1'b0, -1);
  endtask

  task automatic test_rst_mid();
    run_tile(6, 0, 1'b1, ADDR_DIAG, 1'b0, 10);
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.enleft, bus.enup, bus.cmleft, bus.cmup, bus.aleft, bus.bup, bus.op_rd_en, bus.op_rd_k,
         bus.wben, bus.done, bus.busy, bus.err, bus.mixed, bus.addr_type} !== '0) begin
      fails++;
      $display("FAIL rst_mid: got en=%0h/%0h busy=%0b mixed=%0b want all 0", bus.enleft, bus.enup, bus.busy, bus.mixed);
    end
    flush();
    tick(); tick();
    rst = 1'b0;
    run_tile(2, 0, 1'b0, ADDR_COL, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    run_tile(4, 0, 1'b1, ADDR_COL, 1'b0, -1);
    run_tile(1, 0, 1'b0, ADDR_DIAG, 1'b0, -1);
    test_zero_len();
    run_tile(5, 1, 1'b1, ADDR_TILE, 1'b0, -1);
    test_timeout_then_clear();
    run_tile(3, 0, 1'b0, ADDR_COL, 1'b1, -1);
    run_tile(5, 0, 1'b1, ADDR_ROW, 1'b0, -1);
    test_abort();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
